// File: rtl/lzrw1_compressor_core.sv
// LZRW1 streaming compressor: bytes in, 16-bit literal/copy items out.
// Hash table of past positions plus a 4 KiB history window.
module lzrw1_compressor_core #(
    parameter int HASH_BITS  = 12,
    parameter int HIST_BITS  = 12,
    parameter int MAX_LEN    = 18,
    parameter int MAX_OFFSET = 4078
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] item_data,
    output logic        item_is_copy,
    output logic        item_last,
    output logic        item_valid,
    input  logic        item_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_FILL,
        S_HASH,
        S_CMP,
        S_LIT,
        S_OUT
    } state_t;

    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
    localparam logic [15:0] MAX_OFF16 = 16'(MAX_OFFSET);

    logic [7:0]  hist    [2**HIST_BITS];
    logic [15:0] tbl_pos [2**HASH_BITS];
    logic        tbl_vld [2**HASH_BITS];

    state_t                 state, state_n;
    logic [HASH_BITS-1:0]   clr_idx, clr_idx_n;
    logic [15:0]            pos_in, pos_in_n;
    logic [15:0]            p, p_n;
    logic                   last_seen, last_seen_n;
    logic [4:0]             rem, rem_n;
    logic [15:0]            off, off_n;
    logic [4:0]             k, k_n;
    logic [4:0]             adv, adv_n;
    logic [15:0]            item_data_n;
    logic                   item_is_copy_n, item_last_n, item_valid_n;
    logic                   in_ready_n, busy_n;

    logic                   hist_we;
    logic                   tbl_we;
    logic [HASH_BITS-1:0]   tbl_wa;
    logic [15:0]            tbl_wpos;
    logic                   tbl_wvld;

    logic [15:0]            p1, p2, fill_cnt, fill_next, p_adv;
    logic [15:0]            src_pos, dst_pos, cand_off;
    logic [7:0]             hb0, hb1, hb2, cmp_a, cmp_b;
    logic [11:0]            hval;
    logic [HASH_BITS-1:0]   h;
    logic [3:0]             len_code;

    assign hist_we  = in_valid && in_ready;
    assign p1       = p + 16'd1;
    assign p2       = p + 16'd2;
    assign fill_cnt = pos_in - p;
    assign p_adv    = p + {11'd0, adv};
    assign dst_pos  = p + {11'd0, k};
    assign src_pos  = p - off + {11'd0, k};
    assign hb0      = hist[p[HIST_BITS-1:0]];
    assign hb1      = hist[p1[HIST_BITS-1:0]];
    assign hb2      = hist[p2[HIST_BITS-1:0]];
    assign cmp_a    = hist[src_pos[HIST_BITS-1:0]];
    assign cmp_b    = hist[dst_pos[HIST_BITS-1:0]];
    assign hval     = {hb0[3:0], hb1} ^ {hb2, hb0[7:4]};
    assign h        = HASH_BITS'(hval);
    assign cand_off = p - tbl_pos[h];
    assign len_code = 4'(k - 5'd3);

    // History and hash-table storage; the table is invalidated by CLEAR
    always_ff @(posedge clock) begin
        if (hist_we)
            hist[pos_in[HIST_BITS-1:0]] <= in_byte;
        if (tbl_we) begin
            tbl_pos[tbl_wa] <= tbl_wpos;
            tbl_vld[tbl_wa] <= tbl_wvld;
        end
    end

    // Control and item registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_CLEAR;
            clr_idx      <= '0;
            pos_in       <= '0;
            p            <= '0;
            last_seen    <= 1'b0;
            rem          <= '0;
            off          <= '0;
            k            <= '0;
            adv          <= '0;
            item_data    <= '0;
            item_is_copy <= 1'b0;
            item_last    <= 1'b0;
            item_valid   <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b1;
        end else begin
            state        <= state_n;
            clr_idx      <= clr_idx_n;
            pos_in       <= pos_in_n;
            p            <= p_n;
            last_seen    <= last_seen_n;
            rem          <= rem_n;
            off          <= off_n;
            k            <= k_n;
            adv          <= adv_n;
            item_data    <= item_data_n;
            item_is_copy <= item_is_copy_n;
            item_last    <= item_last_n;
            item_valid   <= item_valid_n;
            in_ready     <= in_ready_n;
            busy         <= busy_n;
        end
    end

    // Next-state: input capture, hashing, byte compare and item emission
    always_comb begin
        state_n        = state;
        clr_idx_n      = clr_idx;
        pos_in_n       = pos_in;
        p_n            = p;
        last_seen_n    = last_seen;
        rem_n          = rem;
        off_n          = off;
        k_n            = k;
        adv_n          = adv;
        item_data_n    = item_data;
        item_is_copy_n = item_is_copy;
        item_last_n    = item_last;
        item_valid_n   = item_valid;
        tbl_we         = 1'b0;
        tbl_wa         = h;
        tbl_wpos       = p;
        tbl_wvld       = 1'b1;
        fill_next      = '0;

        if (hist_we) begin
            pos_in_n    = pos_in + 16'd1;
            last_seen_n = last_seen || in_last;
        end

        unique case (state)
            S_CLEAR: begin
                tbl_we      = 1'b1;
                tbl_wa      = clr_idx;
                tbl_wvld    = 1'b0;
                clr_idx_n   = clr_idx + 1'b1;
                pos_in_n    = '0;
                p_n         = '0;
                last_seen_n = 1'b0;
                if (clr_idx == '1)
                    state_n = S_FILL;
            end
            S_FILL: begin
                if (fill_cnt == MAX_LEN16 || last_seen) begin
                    rem_n   = fill_cnt[4:0];
                    state_n = S_HASH;
                end
            end
            S_HASH: begin
                state_n = S_LIT;
                if (rem >= 5'd3) begin
                    tbl_we = 1'b1;
                    if (tbl_vld[h] && cand_off >= 16'd1 &&
                        cand_off <= MAX_OFF16) begin
                        off_n   = cand_off;
                        k_n     = '0;
                        state_n = S_CMP;
                    end
                end
            end
            S_CMP: begin
                if (k < rem && cmp_a == cmp_b) begin
                    k_n = k + 5'd1;
                end else if (k >= 5'd3) begin
                    item_data_n    = {len_code, off[11:0]};
                    item_is_copy_n = 1'b1;
                    item_last_n    = last_seen && (dst_pos == pos_in);
                    item_valid_n   = 1'b1;
                    adv_n          = k;
                    state_n        = S_OUT;
                end else begin
                    state_n = S_LIT;
                end
            end
            S_LIT: begin
                item_data_n    = {8'h00, hb0};
                item_is_copy_n = 1'b0;
                item_last_n    = last_seen && (p1 == pos_in);
                item_valid_n   = 1'b1;
                adv_n          = 5'd1;
                state_n        = S_OUT;
            end
            S_OUT: begin
                fill_next = pos_in_n - p_adv;
                if (item_ready) begin
                    item_valid_n = 1'b0;
                    p_n          = p_adv;
                    if (item_last) begin
                        clr_idx_n = '0;
                        state_n   = S_CLEAR;
                    end else if (fill_next == MAX_LEN16 || last_seen_n) begin
                        rem_n   = fill_next[4:0];
                        state_n = S_HASH;
                    end else begin
                        state_n = S_FILL;
                    end
                end
            end
            default: state_n = S_CLEAR;
        endcase

        in_ready_n = (state_n != S_CLEAR) && !last_seen_n &&
                     ((pos_in_n - p_n) < MAX_LEN16);
        busy_n     = (state_n == S_CLEAR) || (pos_in_n != 16'd0);
    end

endmodule

// File: tb/tb_lzrw1_compressor_core.sv
// Bench for lzrw1_compressor_core: random streams checked against
// a behavioural LZRW1 encoder and an item decoder.
module tb_lzrw1_compressor_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] item_data;
    logic        item_is_copy;
    logic        item_last;
    logic        item_valid;
    logic        item_ready = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  src_q[$];
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    logic        got_last_q[$];
    int          n_acc, n_cons;
    int          gap_pct = 0;
    int          stall_pct = 0;
    int          stall_at = -1;

    lzrw1_compressor_core dut (
        .clock(clock),
        .reset(reset),
        .in_byte(in_byte),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .item_data(item_data),
        .item_is_copy(item_is_copy),
        .item_last(item_last),
        .item_valid(item_valid),
        .item_ready(item_ready),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference LZRW1 encoder over the whole stream
    task automatic build_model();
        int tbl[int];
        int p, n, rem, len, off, h;
        exp_q.delete();
        p = 0;
        n = src_q.size();
        while (p < n) begin
            rem = (n - p < 18) ? n - p : 18;
            len = 0;
            off = 0;
            if (rem >= 3) begin
                h = (((int'(src_q[p]) & 15) << 8) | int'(src_q[p+1])) ^
                    ((int'(src_q[p+2]) << 4) | (int'(src_q[p]) >> 4));
                if (tbl.exists(h)) begin
                    off = (p - tbl[h]) & 65535;
                    if (off >= 1 && off <= 4078)
                        while (len < rem &&
                               src_q[p-off+len] == src_q[p+len])
                            len++;
                end
                tbl[h] = p;
            end
            if (len >= 3) begin
                exp_q.push_back({1'b1, 4'(len - 3), 12'(off)});
                p += len;
            end else begin
                exp_q.push_back({1'b0, 8'h00, src_q[p]});
                p++;
            end
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (n < 10000) begin
            @(posedge clock);
            #1;
            n++;
            if (in_ready) break;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_timeout: in_ready=%b after %0d cycles, want 1",
                     in_ready, n);
        end
    endtask

    task automatic run_stream(input int max_cycles);
        got_q.delete();
        got_last_q.delete();
        n_acc = 0;
        n_cons = 0;
        fork
            begin : drv
                int  i;
                int  cyc;
                bit  hs;
                i = 0;
                cyc = 0;
                while (i < src_q.size() && cyc < max_cycles) begin
                    @(negedge clock);
                    cyc++;
                    in_valid = ($urandom_range(99) >= gap_pct);
                    in_byte  = src_q[i];
                    in_last  = (i == src_q.size() - 1);
                    hs = in_valid && in_ready;
                    @(posedge clock);
                    if (hs) begin
                        i++;
                        n_acc++;
                    end
                end
                @(negedge clock);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            begin : col
                int          cyc;
                int          stall_cnt;
                bit          done;
                bit          held;
                logic [17:0] hv;
                cyc = 0;
                stall_cnt = 0;
                done = 0;
                held = 0;
                hv = '0;
                while (!done && cyc < max_cycles) begin
                    @(negedge clock);
                    cyc++;
                    if (held) begin
                        n_cmp++;
                        if ({item_valid, item_is_copy, item_data, item_last} !==
                            {1'b1, hv}) begin
                            n_bad++;
                            $display("FAIL hold_stable: got %b_%b_%h_%b want 1_%h",
                                     item_valid, item_is_copy, item_data,
                                     item_last, hv);
                        end
                    end
                    if (stall_at >= 0 && got_q.size() == stall_at &&
                        stall_cnt < 50) begin
                        item_ready = 1'b0;
                        stall_cnt++;
                        if (stall_cnt == 50) begin
                            n_cmp++;
                            if (in_ready !== 1'b0) begin
                                n_bad++;
                                $display("FAIL stall_in_ready: got %b want 0",
                                         in_ready);
                            end
                            n_cmp++;
                            if (n_acc != n_cons + 18) begin
                                n_bad++;
                                $display("FAIL stall_buffered: got %0d want %0d",
                                         n_acc - n_cons, 18);
                            end
                        end
                    end else begin
                        item_ready = ($urandom_range(99) >= stall_pct);
                    end
                    held = item_valid && !item_ready;
                    hv = {item_is_copy, item_data, item_last};
                    if (item_valid && item_ready) begin
                        got_q.push_back({item_is_copy, item_data});
                        got_last_q.push_back(item_last);
                        n_cons += item_is_copy ? int'(item_data[15:12]) + 3 : 1;
                        if (item_last) done = 1;
                    end
                end
                @(posedge clock);
                #1;
                item_ready = 1'b0;
                n_cmp++;
                if (!done) begin
                    n_bad++;
                    $display("FAIL stream_timeout: items=%0d want last item",
                             got_q.size());
                end
            end
        join
    endtask

    task automatic check_stream(input string name);
        logic [7:0] dec[$];
        int         nmin, bad_bytes, max_off, off, ln;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s_count: got %0d want %0d", name,
                     got_q.size(), exp_q.size());
        end
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s_item%0d: got %h want %h", name, i,
                         got_q[i], exp_q[i]);
            end
            n_cmp++;
            if (got_last_q[i] !== (i == got_q.size() - 1)) begin
                n_bad++;
                $display("FAIL %s_last%0d: got %b want %b", name, i,
                         got_last_q[i], (i == got_q.size() - 1));
            end
        end
        max_off = 0;
        bad_bytes = 0;
        foreach (got_q[i]) begin
            if (got_q[i][16]) begin
                off = int'(got_q[i][11:0]);
                ln  = int'(got_q[i][15:12]) + 3;
                if (off > max_off) max_off = off;
                if (off == 0 || off > dec.size()) begin
                    bad_bytes++;
                    break;
                end
                for (int j = 0; j < ln; j++)
                    dec.push_back(dec[dec.size() - off]);
            end else begin
                dec.push_back(got_q[i][7:0]);
            end
        end
        for (int i = 0; i < dec.size() && i < src_q.size(); i++)
            if (dec[i] !== src_q[i]) bad_bytes++;
        n_cmp++;
        if (dec.size() != src_q.size() || bad_bytes != 0) begin
            n_bad++;
            $display("FAIL %s_roundtrip: got %0d bytes (%0d wrong) want %0d",
                     name, dec.size(), bad_bytes, src_q.size());
        end
        n_cmp++;
        if (max_off > 4078) begin
            n_bad++;
            $display("FAIL %s_max_off: got %0d want <=4078", name, max_off);
        end
        @(negedge clock);
        n_cmp++;
        if ({busy, in_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL %s_post_clear: busy/in_ready got %b%b want 10",
                     name, busy, in_ready);
        end
    endtask

    task automatic load_str(input string s, input bit use_model);
        src_q.delete();
        for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
        if (use_model) build_model();
    endtask

    task automatic test_reset();
        int n;
        int busy_low;
        #23;
        n_cmp++;
        if ({in_ready, item_valid, item_is_copy, item_last, item_data, busy} !==
            {4'b0000, 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b%b%b%b_%h_%b want 0000_0000_1",
                     in_ready, item_valid, item_is_copy, item_last,
                     item_data, busy);
        end
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        busy_low = 0;
        while (n < 10000) begin
            @(posedge clock);
            #1;
            n++;
            if (in_ready) break;
            if (!busy) busy_low++;
        end
        n_cmp++;
        if (n != 4096) begin
            n_bad++;
            $display("FAIL clear_cycles: got %0d want 4096", n);
        end
        n_cmp++;
        if (busy_low != 0) begin
            n_bad++;
            $display("FAIL clear_busy: busy low %0d cycles want 0", busy_low);
        end
        n_cmp++;
        if ({busy, item_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_state: busy/item_valid got %b%b want 00",
                     busy, item_valid);
        end
    endtask

    task automatic test_abc();
        int n;
        load_str("abc", 0);
        exp_q = '{17'h00061, 17'h00062, 17'h00063};
        gap_pct = 0;
        stall_pct = 0;
        run_stream(2000);
        check_stream("abc");
        wait_idle(n);
    endtask

    task automatic test_abcabc();
        int n;
        load_str("abcabcabc", 0);
        exp_q = '{17'h00061, 17'h00062, 17'h00063, 17'h13003};
        run_stream(2000);
        check_stream("abcabc");
        wait_idle(n);
    endtask

    task automatic test_run_a();
        int n;
        load_str("aaaaaaaaaaaaaaaaaaaa", 0);
        exp_q = '{17'h00061, 17'h1F001, 17'h00061};
        run_stream(2000);
        check_stream("run_a");
        wait_idle(n);
    endtask

    task automatic test_backpressure();
        int n;
        src_q.delete();
        for (int i = 0; i < 100; i++)
            src_q.push_back(8'h61 + 8'($urandom_range(3)));
        build_model();
        gap_pct = 0;
        stall_pct = 0;
        stall_at = 3;
        run_stream(5000);
        stall_at = -1;
        check_stream("backpressure");
        wait_idle(n);
    endtask

    task automatic test_reset_mid();
        int  n, i;
        bit  seen, hs;
        logic [7:0] pat[3];
        pat = '{8'h61, 8'h62, 8'h63};
        seen = 0;
        i = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_byte = pat[i % 3];
            in_last = 1'b0;
            item_ready = 1'b1;
            hs = in_ready;
            if (item_valid && item_is_copy) begin
                seen = 1;
                break;
            end
            @(posedge clock);
            if (hs) i++;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL mid_copy_seen: got 0 want 1");
        end
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        item_ready = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, item_valid, item_data, busy} !== {2'b00, 16'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %b%b_%h_%b want 00_0000_1",
                     in_ready, item_valid, item_data, busy);
        end
        #20;
        @(negedge clock);
        reset = 1'b1;
        wait_idle(n);
        n_cmp++;
        if (n != 4096) begin
            n_bad++;
            $display("FAIL mid_clear_cycles: got %0d want 4096", n);
        end
        load_str("abc", 0);
        exp_q = '{17'h00061, 17'h00062, 17'h00063};
        run_stream(2000);
        check_stream("after_reset");
        wait_idle(n);
    endtask

    task automatic test_random_4k();
        int n, st, ln;
        src_q.delete();
        while (src_q.size() < 4096) begin
            if (src_q.size() > 40 && $urandom_range(99) < 30) begin
                st = $urandom_range(src_q.size() - 21);
                ln = $urandom_range(20, 3);
                for (int j = 0; j < ln && src_q.size() < 4096; j++)
                    src_q.push_back(src_q[st + j]);
            end else begin
                src_q.push_back(8'h41 + 8'($urandom_range(7)));
            end
        end
        build_model();
        gap_pct = 10;
        stall_pct = 15;
        run_stream(60000);
        check_stream("random4k");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_abcabc();
        test_run_a();
        test_backpressure();
        test_reset_mid();
        test_random_4k();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
